// File: rtl/nco_pkg.sv
// Shared types and helpers for the quadrature NCO: quadrant enum, pipeline depth
// and the elaboration-time quarter-wave sine table generator.
package nco_pkg;

  typedef enum logic [1:0] {
    Q0 = 2'd0,
    Q1 = 2'd1,
    Q2 = 2'd2,
    Q3 = 2'd3
  } quad_e;

  localparam int NCO_LATENCY = 4;

  // Fixed-point format used while building the table: Q30, pi/2 pre-scaled.
  localparam int     ROM_FRAC_W   = 30;
  localparam int     ROM_TERMS    = 9;
  localparam longint PI_HALF_Q30  = 64'sd1686629713;

  function automatic quad_e quad_next(input quad_e q);
    quad_e res;
    case (q)
      Q0:      res = Q1;
      Q1:      res = Q2;
      Q2:      res = Q3;
      Q3:      res = Q0;
      default: res = Q0;
    endcase
    return res;
  endfunction

  function automatic logic quad_is_odd(input quad_e q);
    logic res;
    case (q)
      Q1, Q3:  res = 1'b1;
      Q0, Q2:  res = 1'b0;
      default: res = 1'b0;
    endcase
    return res;
  endfunction

  function automatic logic quad_is_neg(input quad_e q);
    logic res;
    case (q)
      Q2, Q3:  res = 1'b1;
      Q0, Q1:  res = 1'b0;
      default: res = 1'b0;
    endcase
    return res;
  endfunction

  // round(full_scale * sin(pi/2 * idx / 2**lut_aw)) via a Taylor series in Q30;
  // only ever evaluated on constants, so it folds away at elaboration.
  function automatic longint nco_rom_entry(input int idx, input int lut_aw, input int amp_w);
    longint full_scale;
    longint x;
    longint term;
    longint acc;
    longint val;
    full_scale = (64'sd1 <<< (amp_w - 32'sd1)) - 64'sd1;
    x          = (PI_HALF_Q30 * longint'(idx)) >>> lut_aw;
    term       = x;
    acc        = x;
    for (int k = 1; k <= ROM_TERMS; k++) begin
      term = (term * x) >>> ROM_FRAC_W;
      term = (term * x) >>> ROM_FRAC_W;
      term = -term / longint'((32'sd2 * k) * (32'sd2 * k + 32'sd1));
      acc  = acc + term;
    end
    val = (acc * full_scale + (64'sd1 <<< (ROM_FRAC_W - 32'sd1))) >>> ROM_FRAC_W;
    if (val < 64'sd0) begin
      val = 64'sd0;
    end else if (val > full_scale) begin
      val = full_scale;
    end else begin
      val = val;
    end
    return val;
  endfunction

endpackage

// File: rtl/nco_qwave_rom.sv
// Quarter-wave sine magnitude ROM, 2**LUT_AW+1 entries, two registered read ports
// sharing one table (sine and cosine lookups).
module nco_qwave_rom
  import nco_pkg::*;
#(
  parameter int LUT_AW = 10,
  parameter int AMP_W  = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_en,
  input  logic [LUT_AW:0]   i_addr_a,
  input  logic [LUT_AW:0]   i_addr_b,
  output logic [AMP_W-2:0]  o_data_a,
  output logic [AMP_W-2:0]  o_data_b
);

  localparam int DEPTH = (32'sd1 <<< LUT_AW) + 32'sd1;

  logic [AMP_W-2:0] w_rom [DEPTH];
  logic [AMP_W-2:0] r_data_a;
  logic [AMP_W-2:0] r_data_b;

  for (genvar g = 0; g < DEPTH; g++) begin : g_rom
    localparam longint ROM_RAW = nco_rom_entry(g, LUT_AW, AMP_W);
    assign w_rom[g] = ROM_RAW[AMP_W-2:0];
  end

  // Registered table read; holds while the pipeline is stalled.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_data_a <= '0;
      r_data_b <= '0;
    end else if (i_en) begin
      r_data_a <= w_rom[i_addr_a];
      r_data_b <= w_rom[i_addr_b];
    end
  end

  assign o_data_a = r_data_a;
  assign o_data_b = r_data_b;

endmodule

// File: rtl/nco_iq_param.sv
// Quadrature NCO: phase accumulator with runtime increment reload, phase offset and
// sync clear, feeding a four-stage fold / ROM / sign pipeline with clock-enable stall.
module nco_iq_param
  import nco_pkg::*;
#(
  parameter int PHASE_W = 32,
  parameter int LUT_AW  = 10,
  parameter int AMP_W   = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               clken,
  input  logic [PHASE_W-1:0] phi_inc_i,
  input  logic               phi_inc_load,
  input  logic [PHASE_W-1:0] phase_ofs_i,
  input  logic               phase_sync,
  output logic [AMP_W-1:0]   fsin_o,
  output logic [AMP_W-1:0]   fcos_o,
  output logic               out_valid
);

  localparam logic [LUT_AW:0] LUT_EDGE = {1'b1, {LUT_AW{1'b0}}};

  logic [PHASE_W-1:0]     r_acc;
  logic [PHASE_W-1:0]     r_inc;
  logic [PHASE_W-1:0]     w_phase;
  logic                   w_unused_phase;
  quad_e                  w_sin_q;
  quad_e                  w_cos_q;
  logic [LUT_AW-1:0]      w_addr;

  quad_e                  r_s1_sin_q;
  quad_e                  r_s1_cos_q;
  logic [LUT_AW-1:0]      r_s1_addr;

  logic [LUT_AW:0]        w_sin_idx;
  logic [LUT_AW:0]        w_cos_idx;
  logic [LUT_AW:0]        r_s2_sin_idx;
  logic [LUT_AW:0]        r_s2_cos_idx;
  logic                   r_s2_sin_neg;
  logic                   r_s2_cos_neg;

  logic [AMP_W-2:0]       w_rom_sin;
  logic [AMP_W-2:0]       w_rom_cos;
  logic                   r_s3_sin_neg;
  logic                   r_s3_cos_neg;

  logic [AMP_W-1:0]       w_sin_val;
  logic [AMP_W-1:0]       w_cos_val;
  logic [AMP_W-1:0]       r_fsin;
  logic [AMP_W-1:0]       r_fcos;
  logic [NCO_LATENCY-1:0] r_vpipe;

  // Increment reload ignores clken; the accumulator uses the old increment on a load edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_inc <= '0;
      r_acc <= '0;
    end else begin
      if (phi_inc_load) begin
        r_inc <= phi_inc_i;
      end
      if (clken) begin
        if (phase_sync) begin
          r_acc <= '0;
        end else begin
          r_acc <= r_acc + r_inc;
        end
      end
    end
  end

  // Cosine is the same phase advanced by one quadrant, so only the quadrant differs.
  always_comb begin
    w_phase = r_acc + phase_ofs_i;
    w_sin_q = quad_e'(w_phase[PHASE_W-1 -: 2]);
    w_cos_q = quad_next(w_sin_q);
    w_addr  = w_phase[PHASE_W-3 -: LUT_AW];
  end

  assign w_unused_phase = ^w_phase;

  // Stage 1: sampled phase decode.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_s1_sin_q <= Q0;
      r_s1_cos_q <= Q0;
      r_s1_addr  <= '0;
    end else if (clken) begin
      r_s1_sin_q <= w_sin_q;
      r_s1_cos_q <= w_cos_q;
      r_s1_addr  <= w_addr;
    end
  end

  // Odd quadrants read the table backwards; a=0 there lands on the full-scale entry.
  always_comb begin
    w_sin_idx = {1'b0, r_s1_addr};
    w_cos_idx = {1'b0, r_s1_addr};
    if (quad_is_odd(r_s1_sin_q)) begin
      w_sin_idx = LUT_EDGE - {1'b0, r_s1_addr};
    end else begin
      w_sin_idx = {1'b0, r_s1_addr};
    end
    if (quad_is_odd(r_s1_cos_q)) begin
      w_cos_idx = LUT_EDGE - {1'b0, r_s1_addr};
    end else begin
      w_cos_idx = {1'b0, r_s1_addr};
    end
  end

  // Stage 2: folded table index and sign.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_s2_sin_idx <= '0;
      r_s2_cos_idx <= '0;
      r_s2_sin_neg <= 1'b0;
      r_s2_cos_neg <= 1'b0;
    end else if (clken) begin
      r_s2_sin_idx <= w_sin_idx;
      r_s2_cos_idx <= w_cos_idx;
      r_s2_sin_neg <= quad_is_neg(r_s1_sin_q);
      r_s2_cos_neg <= quad_is_neg(r_s1_cos_q);
    end
  end

  nco_qwave_rom #(
    .LUT_AW (LUT_AW),
    .AMP_W  (AMP_W)
  ) u_rom (
    .clk      (clk),
    .reset    (reset),
    .i_en     (clken),
    .i_addr_a (r_s2_sin_idx),
    .i_addr_b (r_s2_cos_idx),
    .o_data_a (w_rom_sin),
    .o_data_b (w_rom_cos)
  );

  // Stage 3: sign travels alongside the registered table read.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_s3_sin_neg <= 1'b0;
      r_s3_cos_neg <= 1'b0;
    end else if (clken) begin
      r_s3_sin_neg <= r_s2_sin_neg;
      r_s3_cos_neg <= r_s2_cos_neg;
    end
  end

  // Table magnitude never exceeds 2**(AMP_W-1)-1, so negation cannot reach the most negative code.
  always_comb begin
    w_sin_val = {1'b0, w_rom_sin};
    w_cos_val = {1'b0, w_rom_cos};
    if (r_s3_sin_neg) begin
      w_sin_val = -{1'b0, w_rom_sin};
    end else begin
      w_sin_val = {1'b0, w_rom_sin};
    end
    if (r_s3_cos_neg) begin
      w_cos_val = -{1'b0, w_rom_cos};
    end else begin
      w_cos_val = {1'b0, w_rom_cos};
    end
  end

  // Stage 4: output registers and valid shift chain.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_fsin  <= '0;
      r_fcos  <= '0;
      r_vpipe <= '0;
    end else if (clken) begin
      r_fsin  <= w_sin_val;
      r_fcos  <= w_cos_val;
      r_vpipe <= {r_vpipe[NCO_LATENCY-2:0], 1'b1};
    end
  end

  assign fsin_o    = r_fsin;
  assign fcos_o    = r_fcos;
  assign out_valid = clken & r_vpipe[NCO_LATENCY-1];

endmodule

// File: tb/tb_nco_iq_param.sv
// Scoreboard bench for nco_iq_param: a real-valued sin/cos model of the truncated
// phase pushes expectations each enabled edge; DUT outputs are popped and compared.
module tb_nco_iq_param;

  localparam real PI = 3.14159265358979323846;
  localparam int  FS = 32767;

  logic        clk;
  logic        reset;
  logic        clken;
  logic [31:0] phi_inc_i;
  logic        phi_inc_load;
  logic [31:0] phase_ofs_i;
  logic        phase_sync;
  logic [15:0] fsin_o;
  logic [15:0] fcos_o;
  logic        out_valid;

  int n_checks = 0;
  int n_fail   = 0;

  int sb_sin[$];
  int sb_cos[$];
  int got_sin[$];
  int got_cos[$];

  logic [31:0] m_acc;
  logic [31:0] m_inc;
  int          m_cnt;
  int          last_sin;
  int          last_cos;

  nco_iq_param dut (
    .clk          (clk),
    .reset        (reset),
    .clken        (clken),
    .phi_inc_i    (phi_inc_i),
    .phi_inc_load (phi_inc_load),
    .phase_ofs_i  (phase_ofs_i),
    .phase_sync   (phase_sync),
    .fsin_o       (fsin_o),
    .fcos_o       (fcos_o),
    .out_valid    (out_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic signed [31:0] observed,
                           input logic signed [31:0] expected);
    n_checks++;
    if (observed !== expected) begin
      n_fail++;
      $display("FAIL %s: observed %0d expected %0d", tag, observed, expected);
    end
  endtask

  function automatic int exp_amp(input logic [31:0] ph, input bit want_cos);
    real ang;
    real v;
    ang = 2.0 * PI * real'(int'(ph[31:20])) / 4096.0;
    v   = real'(FS) * (want_cos ? $cos(ang) : $sin(ang));
    if (v >= 0.0) return int'($floor(v + 0.5));
    else          return -int'($floor(-v + 0.5));
  endfunction

  // One clock: update the model from the inputs now applied, then check at the falling edge.
  task automatic tick();
    logic [31:0] ph;
    bit          rst_edge;
    bit          exp_valid;
    rst_edge = reset;
    if (reset) begin
      sb_sin.delete(); sb_cos.delete(); got_sin.delete(); got_cos.delete();
      m_acc = '0; m_inc = '0; m_cnt = 0; last_sin = 0; last_cos = 0;
    end else begin
      if (clken) begin
        ph = m_acc + phase_ofs_i;
        sb_sin.push_back(exp_amp(ph, 1'b0));
        sb_cos.push_back(exp_amp(ph, 1'b1));
        m_acc = phase_sync ? 32'h0 : m_acc + m_inc;
        if (m_cnt < 4) m_cnt++;
      end
      if (phi_inc_load) m_inc = phi_inc_i;
    end
    @(posedge clk);
    @(negedge clk);
    exp_valid = !reset && clken && (m_cnt >= 4);
    check_val("out_valid", {31'b0, out_valid}, {31'b0, exp_valid});
    if (exp_valid) begin
      if (sb_sin.size() > 0) begin
        last_sin = sb_sin.pop_front();
        last_cos = sb_cos.pop_front();
      end else begin
        check_val("sb_underflow", 0, 1);
      end
      got_sin.push_back(int'($signed(fsin_o)));
      got_cos.push_back(int'($signed(fcos_o)));
    end
    if (exp_valid || rst_edge || (!reset && !clken && m_cnt >= 4)) begin
      check_val("fsin", $signed(fsin_o), last_sin);
      check_val("fcos", $signed(fcos_o), last_cos);
    end
  endtask

  task automatic expect_sample(input string tag, input int idx, input int es, input int ec);
    if (idx < got_sin.size()) begin
      check_val({tag, "_sin"}, got_sin[idx], es);
      check_val({tag, "_cos"}, got_cos[idx], ec);
    end else begin
      check_val({tag, "_count"}, got_sin.size(), idx + 1);
    end
  endtask

  task automatic restart(input int rst_cycles, input logic [31:0] inc, input logic [31:0] ofs);
    reset = 1'b1; clken = 1'b1; phase_sync = 1'b0; phi_inc_load = 1'b0;
    repeat (rst_cycles) tick();
    reset = 1'b0; clken = 1'b0; phi_inc_load = 1'b1; phi_inc_i = inc; phase_ofs_i = ofs;
    tick();
    phi_inc_load = 1'b0; clken = 1'b1;
  endtask

  initial begin
    reset = 1'b1; clken = 1'b1; phi_inc_i = '0; phi_inc_load = 1'b0;
    phase_ofs_i = '0; phase_sync = 1'b0;
    m_acc = '0; m_inc = '0; m_cnt = 0; last_sin = 0; last_cos = 0;

    // Scenario 1: quarter-turn increment, seven reset cycles.
    restart(7, 32'h4000_0000, 32'h0);
    repeat (12) tick();
    expect_sample("s1_0", 0, 0, FS);
    expect_sample("s1_1", 1, FS, 0);
    expect_sample("s1_2", 2, 0, -FS);
    expect_sample("s1_3", 3, -FS, 0);

    // Scenario 4: clken 1,0,0,1 stall mid-run.
    clken = 1'b0; tick(); tick();
    clken = 1'b1; repeat (6) tick();

    // Scenario 5: sync and load in the same cycle.
    got_sin.delete(); got_cos.delete();
    phase_sync = 1'b1; phi_inc_load = 1'b1; phi_inc_i = 32'h2000_0000;
    tick();
    phase_sync = 1'b0; phi_inc_load = 1'b0;
    repeat (8) tick();
    expect_sample("s5_sync", 4, 0, FS);
    expect_sample("s5_45deg", 5, 23170, 23170);
    expect_sample("s5_90deg", 6, FS, 0);

    // Scenario 6: one-cycle reset mid-stream.
    reset = 1'b1; tick();
    reset = 1'b0; repeat (6) tick();
    expect_sample("s6_first", 0, 0, FS);

    // Scenario 2: half-turn offset negates scenario 1.
    restart(2, 32'h4000_0000, 32'h8000_0000);
    repeat (10) tick();
    expect_sample("s2_0", 0, 0, -FS);
    expect_sample("s2_1", 1, -FS, 0);
    expect_sample("s2_2", 2, 0, FS);
    expect_sample("s2_3", 3, FS, 0);

    // Scenario 3: all-ones increment walks backwards from zero.
    restart(2, 32'hFFFF_FFFF, 32'h0);
    repeat (12) tick();
    expect_sample("s3_0", 0, 0, FS);
    expect_sample("s3_1", 1, -50, FS);
    expect_sample("s3_5", 5, -50, FS);

    // Randomised increments, offsets, syncs and stalls against the model.
    restart(2, 32'h0123_4567, 32'h0);
    for (int i = 0; i < 60; i++) begin
      clken        = ($urandom_range(0, 4) != 0);
      phi_inc_load = ($urandom_range(0, 5) == 0);
      phi_inc_i    = $urandom();
      phase_ofs_i  = $urandom();
      phase_sync   = ($urandom_range(0, 15) == 0);
      tick();
    end
    clken = 1'b1; phi_inc_load = 1'b0; phase_sync = 1'b0;
    repeat (6) tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
